// File: rtl/sync_mem_arbiter.sv
// Two-requester arbiter for a single synchronous memory port with read-response routing.
// Define SYNC_MEM_ARB_STATS_EN to add the grant/starvation statistics counters.
module sync_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 21,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic                    req0_wen,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_mask,
    input  logic                    req0_lock,
    output logic                    resp0_valid,
    output logic [DATA_WIDTH-1:0]   resp0_data,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic                    req1_wen,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_mask,
    output logic                    resp1_valid,
    output logic [DATA_WIDTH-1:0]   resp1_data,

    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_mask,
    output logic                    mem_wen,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef SYNC_MEM_ARB_STATS_EN
    ,
    output logic [31:0]             stat_grant0,
    output logic [31:0]             stat_grant1,
    output logic [15:0]             stat_starve
`endif
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        StIdle,
        StLocked0
    } state_e;

    state_e     state;
    logic [3:0] starve_cnt;
    logic       pend_valid;
    logic       pend_id;

    logic idle_arb;
    logic force1;
    logic grant0;
    logic grant1;
    logic grant_read;

    // A locked port falls back to normal arbitration in the cycle the lock drops.
    always_comb begin
        idle_arb   = (state == StIdle) || !req0_lock;
        force1     = idle_arb && req1_valid && (starve_cnt == STARVE_MAX);
        grant0     = !reset && req0_valid && !force1;
        grant1     = !reset && idle_arb && req1_valid && (force1 || !req0_valid);
        grant_read = (grant0 && !req0_wen) || (grant1 && !req1_wen);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        mem_wen   = 1'b0;
        if (grant0) begin
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
            mem_mask  = req0_mask;
            mem_wen   = req0_wen;
        end else if (grant1) begin
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
            mem_mask  = req1_mask;
            mem_wen   = req1_wen;
        end
    end

    // Reset also squashes a response owed to a read issued just before it.
    always_comb begin
        resp0_valid = !reset && pend_valid && !pend_id;
        resp1_valid = !reset && pend_valid && pend_id;
        resp0_data  = resp0_valid ? mem_rdata : '0;
        resp1_data  = resp1_valid ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            starve_cnt <= 4'd0;
            pend_valid <= 1'b0;
            pend_id    <= 1'b0;
        end else begin
            if (idle_arb) begin
                state <= (grant0 && req0_lock) ? StLocked0 : StIdle;
            end else begin
                state <= StLocked0;
            end

            if (!req1_valid || grant1) begin
                starve_cnt <= 4'd0;
            end else if (grant0 && idle_arb && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            pend_valid <= grant_read;
            if (grant_read) begin
                pend_id <= grant1;
            end
        end
    end

`ifdef SYNC_MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
            stat_starve <= '0;
        end else begin
            if (grant0) begin
                stat_grant0 <= stat_grant0 + 32'd1;
            end
            if (grant1) begin
                stat_grant1 <= stat_grant1 + 32'd1;
            end
            if (grant1 && force1) begin
                stat_starve <= stat_starve + 16'd1;
            end
        end
    end
`endif

    logic unused_mask_width;
    assign unused_mask_width = ^MASK_WIDTH;

endmodule

// File: tb/tb_sync_mem_arbiter.sv
// Self-checking bench for sync_mem_arbiter: directed scenarios followed by random traffic,
// all compared against a byte-level reference model of the arbitration rules.
module tb_sync_mem_arbiter;

    localparam int unsigned AW    = 21;
    localparam int unsigned DW    = 32;
    localparam int unsigned MW    = 4;
    localparam int unsigned LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0_valid, req0_ready, req0_wen, req0_lock, resp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, resp0_data;
    logic [MW-1:0] req0_mask;
    logic          req1_valid, req1_ready, req1_wen, resp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, resp1_data;
    logic [MW-1:0] req1_mask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_mask;
    logic          mem_wen;
`ifdef SYNC_MEM_ARB_STATS_EN
    logic [31:0]   stat_grant0, stat_grant1;
    logic [15:0]   stat_starve;
`endif

    sync_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wen(req0_wen), .req0_wdata(req0_wdata), .req0_mask(req0_mask),
        .req0_lock(req0_lock), .resp0_valid(resp0_valid), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wen(req1_wen), .req1_wdata(req1_wdata), .req1_mask(req1_mask),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata)
`ifdef SYNC_MEM_ARB_STATS_EN
        ,
        .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_starve(stat_starve)
`endif
    );

    // Environment memory: word-wide, registered read, masked write.
    bit [31:0] env_mem [256];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_wen) env_mem[mem_addr[9:2]] <= merge(env_mem[mem_addr[9:2]], mem_wdata, mem_mask);
        else         mem_rdata <= env_mem[mem_addr[9:2]];
    end

    // Reference model state.
    bit [7:0]    ref_mem [1024];
    int          starve_m;
    bit          locked_m;
    bit          exp_v, exp_id;
    logic [31:0] exp_d;
    int unsigned n_g0, n_g1, n_force;
    bit          m_g0, m_g1;

    bit          obs_g0, obs_g1, obs_wen, obs_r0v, obs_r1v;
    logic [31:0] obs_r0d, obs_r1d;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = ref_mem[{a[9:2], 2'(b)}];
        return r;
    endfunction

    // One clock cycle: inputs already driven at the falling edge.
    task automatic step();
        bit          idle_arb, forced, g0m, g1m, ew, r0v_e, r1v_e;
        logic [20:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        #1;
        idle_arb = !locked_m || !req0_lock;
        forced   = !reset && idle_arb && req1_valid && (starve_m == LIMIT);
        g0m      = !reset && req0_valid && !forced;
        g1m      = !reset && idle_arb && req1_valid && !g0m;
        ea = g0m ? req0_addr  : g1m ? req1_addr  : '0;
        ed = g0m ? req0_wdata : g1m ? req1_wdata : '0;
        em = g0m ? req0_mask  : g1m ? req1_mask  : '0;
        ew = g0m ? req0_wen   : g1m ? req1_wen   : 1'b0;
        r0v_e = !reset && exp_v && !exp_id;
        r1v_e = !reset && exp_v && exp_id;

        check_eq("req0_ready", req0_ready, g0m);
        check_eq("req1_ready", req1_ready, g1m);
        check_eq("mem_wen", mem_wen, ew);
        check_eq("mem_addr", mem_addr, ea);
        check_eq("mem_wdata", mem_wdata, ed);
        check_eq("mem_mask", mem_mask, em);
        check_eq("resp0_valid", resp0_valid, r0v_e);
        check_eq("resp1_valid", resp1_valid, r1v_e);
        check_eq("resp0_data", resp0_data, r0v_e ? exp_d : 32'h0);
        check_eq("resp1_data", resp1_data, r1v_e ? exp_d : 32'h0);
`ifdef SYNC_MEM_ARB_STATS_EN
        check_eq("stat_grant0", stat_grant0, n_g0);
        check_eq("stat_grant1", stat_grant1, n_g1);
        check_eq("stat_starve", stat_starve, n_force[15:0]);
`endif
        obs_g0 = req0_ready; obs_g1 = req1_ready; obs_wen = mem_wen;
        obs_r0v = resp0_valid; obs_r0d = resp0_data;
        obs_r1v = resp1_valid; obs_r1d = resp1_data;

        m_g0 = g0m; m_g1 = g1m;
        if (reset) begin
            starve_m = 0; locked_m = 0; exp_v = 0;
            n_g0 = 0; n_g1 = 0; n_force = 0;
        end else begin
            if (g0m || g1m) begin
                if (ew) for (int b = 0; b < 4; b++)
                    if (em[b]) ref_mem[{ea[9:2], 2'(b)}] = ed[8*b +: 8];
                exp_v  = !ew;
                exp_id = g1m;
                exp_d  = ref_read(ea);
            end else begin
                exp_v = 0;
            end
            if (!req1_valid || g1m) starve_m = 0;
            else if (g0m && idle_arb && starve_m < LIMIT) starve_m++;
            locked_m = idle_arb ? (g0m && req0_lock) : 1'b1;
            if (g0m) n_g0++;
            if (g1m) n_g1++;
            if (forced) n_force++;
        end
        @(negedge clk);
    endtask

    task automatic clr();
        req0_valid = 0; req0_addr = '0; req0_wen = 0; req0_wdata = '0; req0_mask = '0;
        req0_lock = 0;
        req1_valid = 0; req1_addr = '0; req1_wen = 0; req1_wdata = '0; req1_mask = '0;
    endtask

    task automatic set0(input bit v, input int a, input bit w, input logic [31:0] d,
                        input logic [3:0] m);
        req0_valid = v; req0_addr = AW'(a); req0_wen = w; req0_wdata = d; req0_mask = m;
    endtask

    task automatic set1(input bit v, input int a, input bit w, input logic [31:0] d,
                        input logic [3:0] m);
        req1_valid = v; req1_addr = AW'(a); req1_wen = w; req1_wdata = d; req1_mask = m;
    endtask

    initial begin
        bit [9:0] seq;
        int       n1, gcyc;
        bit       got;

        clr();
        reset = 1;
        @(negedge clk);
        set0(1, 'h40, 1, 32'h1, 4'hF);
        set1(1, 'h44, 0, 32'h0, 4'h0);
        step();
        check_eq("reset_no_grant", {obs_g0, obs_g1, obs_wen}, 3'b000);
        reset = 0;
        clr();
        step();

        // Write then read back the same word.
        set0(1, 'h100, 1, 32'hDEADBEEF, 4'hF);
        step();
        check_eq("t1_wen", obs_wen, 1);
        set0(1, 'h100, 0, 32'h0, 4'h0);
        step();
        clr();
        step();
        check_eq("t1_resp0_valid", obs_r0v, 1);
        check_eq("t1_resp0_data", obs_r0d, 32'hDEADBEEF);
        check_eq("t1_resp1_valid", obs_r1v, 0);

        // Both requesters busy: the starvation guard forces every fifth grant to req1.
        set0(1, 'h10, 1, 32'h0A0A0A0A, 4'hF);
        set1(1, 'h14, 1, 32'h1B1B1B1B, 4'hF);
        for (int i = 0; i < 10; i++) begin
            step();
            seq[i] = obs_g1;
        end
        check_eq("starve_seq", seq, 10'b1000010000);
`ifdef SYNC_MEM_ARB_STATS_EN
        check_eq("starve_stat", stat_starve, 16'd2);
`endif
        clr();
        step();

        // Lock held for eight cycles keeps req1 out; release restores normal arbitration.
        set0(1, 'h20, 1, 32'h22222222, 4'hF);
        req0_lock = 1;
        set1(1, 'h24, 0, 32'h0, 4'h0);
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            n1 += int'(obs_g1);
        end
        check_eq("lock_blocks_req1", n1, 0);
        req0_lock = 0;
        got = 0;
        gcyc = 99;
        for (int i = 8; i < 16 && !got; i++) begin
            step();
            if (obs_g1) begin
                got = 1;
                gcyc = i;
            end
        end
        check_eq("lock_release_grant", (got && gcyc <= 12), 1);
        clr();
        step();

        // Interleaved reads from both requesters route back to their owners.
        set1(1, 'h200, 1, 32'hA5A50200, 4'hF);
        step();
        clr();
        set0(1, 'h204, 1, 32'h5A5A0204, 4'hF);
        step();
        clr();
        set1(1, 'h200, 0, 32'h0, 4'h0);
        step();
        clr();
        set0(1, 'h204, 0, 32'h0, 4'h0);
        step();
        check_eq("alt_resp1_valid", obs_r1v, 1);
        check_eq("alt_resp1_data", obs_r1d, 32'hA5A50200);
        check_eq("alt_resp0_idle", obs_r0v, 0);
        clr();
        step();
        check_eq("alt_resp0_valid", obs_r0v, 1);
        check_eq("alt_resp0_data", obs_r0d, 32'h5A5A0204);
        check_eq("alt_resp1_idle", obs_r1v, 0);

        // Partial byte-mask write over a preloaded word.
        set0(1, 'h300, 1, 32'h11223344, 4'hF);
        step();
        set0(1, 'h300, 1, 32'h0000AB00, 4'h2);
        step();
        set0(1, 'h300, 0, 32'h0, 4'h0);
        step();
        clr();
        step();
        check_eq("mask_resp0_data", obs_r0d, 32'h1122AB44);

        // Reset right after a read grant drops its response.
        set1(1, 'h200, 0, 32'h0, 4'h0);
        step();
        check_eq("rst_read_granted", obs_g1, 1);
        clr();
        reset = 1;
        step();
        check_eq("rst_resp1_squashed", obs_r1v, 0);
        reset = 0;
        set1(1, 'h200, 0, 32'h0, 4'h0);
        step();
        check_eq("rst_pend_cleared", obs_r1v, 0);
        clr();
        step();
        check_eq("post_rst_resp1_valid", obs_r1v, 1);
        check_eq("post_rst_resp1_data", obs_r1d, 32'hA5A50200);

        // Random traffic; unaccepted requests are held stable.
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!req0_valid || m_g0)
                set0($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) << 2,
                     1'($urandom), $urandom, 4'($urandom));
            if (!req1_valid || m_g1)
                set1($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) << 2,
                     1'($urandom), $urandom, 4'($urandom));
            if ($urandom_range(0, 7) == 0) req0_lock = !req0_lock;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_mem_arbiter.md
Name: sync_mem_arbiter

Overview:
- Shares one byte-addressed synchronous memory port between two requesters: req0 (host/debug loader) and req1 (core data port).
- The memory registers its read address and returns read data one cycle after issue. This block tracks which requester issued each read and routes the data back.
- Arbitration is fixed-priority with a starvation guard, and req0 can lock the port for multi-access host sequences.

Parameters:
- ADDR_WIDTH, 21, byte address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8. MASK_WIDTH = DATA_WIDTH/8 is derived and is not a parameter.
- STARVE_LIMIT, 4, number of consecutive req0 grants allowed while req1 waits before req1 is forced (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 access request.
- req0_ready  out  1  grant to requester 0 this cycle.
- req0_addr  in  ADDR_WIDTH  byte address.
- req0_wen  in  1  1 = write, 0 = read.
- req0_wdata  in  DATA_WIDTH  write data.
- req0_mask  in  MASK_WIDTH  byte-enable mask.
- req0_lock  in  1  hold the port for requester 0 while asserted.
- resp0_valid  out  1  read data valid for requester 0.
- resp0_data  out  DATA_WIDTH  read data for requester 0.
- req1_valid, req1_ready, req1_addr, req1_wen, req1_wdata, req1_mask, resp1_valid, resp1_data: same widths and meanings for requester 1. Requester 1 has no lock input.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_mask  out  MASK_WIDTH  memory byte mask.
- mem_wen  out  1  memory write enable.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read is issued.

Behaviour:
- Handshake: an access transfers in a cycle where reqN_valid and reqN_ready are both 1. At most one ready is high per cycle. readyN depends combinationally on the valids and registered state, never on readyN itself.
- Requesters must hold addr, wen, wdata and mask stable while valid && !ready.
- States: IDLE and LOCKED0.
  - IDLE: if req1_valid and starve_cnt == STARVE_LIMIT, grant req1. Otherwise grant req0 if req0_valid. Otherwise grant req1 if req1_valid.
  - IDLE -> LOCKED0 on a req0 grant with req0_lock = 1.
  - LOCKED0: only req0 is granted; req1_ready = 0 and the starvation guard is suspended.
  - LOCKED0 -> IDLE on the first cycle req0_lock = 0 (sampled). That cycle is arbitrated as IDLE.
- starve_cnt (4 bits):
  - Increments on each req0 grant while req1_valid = 1 in IDLE.
  - Clears on a req1 grant, and in any cycle with req1_valid = 0.
  - Saturates at STARVE_LIMIT.
- Memory mux:
  - mem_addr, mem_wdata and mem_mask come from the granted requester.
  - With no grant they drive 0.
  - mem_wen = grant && wen of the granted requester.
- Read response:
  - A granted read sets pend_valid and records pend_id (0 or 1).
  - Next cycle: respN_valid = pend_valid && pend_id == N, and respN_data = mem_rdata. The non-matching resp_data drives 0.
  - Writes produce no response.
  - Back-to-back reads are fully pipelined, one per cycle, with throughput 1.
- Same-address write then read on consecutive cycles returns the new data. The memory's write-first ordering provides this; the arbiter adds no forwarding.
- Reset:
  - Forces state to IDLE, starve_cnt = 0, pend_valid = 0.
  - All ready, resp_valid and mem_wen outputs are 0 during the reset cycle, regardless of the valids.
  - A read granted in the cycle before reset asserts produces no response.

Optional Feature:
- SYNC_MEM_ARB_STATS_EN defined:
  - Adds outputs stat_grant0 [31:0], stat_grant1 [31:0] and stat_starve [15:0].
  - stat_grant0 and stat_grant1 count grants per requester. stat_starve counts forced req1 grants.
  - All three clear on reset and wrap on overflow.
- Undefined: these ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Req0 write addr 0x100, data 0xDEADBEEF, mask 0xF, then read 0x100 next cycle -> mem_wen=1 in cycle 0; resp0_valid=1 with 0xDEADBEEF in cycle 2; resp1_valid stays 0.
- Both valid continuously, STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; with stats enabled, stat_starve=2 after 10 cycles.
- Req0 lock held 8 cycles with req1 valid throughout -> req1_ready=0 for all 8 cycles. Lock drops in cycle 8 -> arbitrated as IDLE; req1 is granted by cycle 12 at the latest.
- Alternating reads: req1 reads 0x200, then req0 reads 0x204 -> resp1 then resp0 on consecutive cycles, each carrying its own data with no cross-routing.
- Partial write mask 0x2, data 0x0000AB00 to 0x300 (preloaded 0x11223344), then read -> 0x1122AB44.
- Reset asserted the cycle after a req1 read grant -> resp1_valid=0 and pend cleared. After reset, first read works normally with 1-cycle latency.
